// File: rtl/cordic_pkg.sv
// Shared widths, constants and arctangent table for the pipelined CORDIC sin/cos.
package cordic_pkg;

    localparam int unsigned IO_W     = 16;
    localparam int unsigned INT_W    = 18;
    localparam int unsigned ITER_DEF = 16;
    localparam int unsigned Z_SHIFT  = 2;      // Q2.13 angle -> 2^15 internal z scale

    localparam int K_FIX    = 39797;           // round(0.6072529 * 2^16)
    localparam int SAT_MAX  = 16384;           // +1.0 in Q1.14

    localparam logic signed [IO_W-1:0] PI_Q13      = 16'sh6488;
    localparam logic signed [IO_W-1:0] HALF_PI_Q13 = 16'sh3244;
    localparam int                     PI_Z        = 25736 * 4;

    typedef logic signed [INT_W-1:0] dat_t;

    typedef struct packed {
        dat_t x;
        dat_t y;
        dat_t z;
        logic neg;
    } cordic_stage_t;

    // round(atan(2^-i) * 2^15); zero beyond the representable range
    function automatic dat_t atan_lut(input int unsigned i);
        dat_t r;
        case (i)
            0:       r = 18'sd25736;
            1:       r = 18'sd15193;
            2:       r = 18'sd8027;
            3:       r = 18'sd4075;
            4:       r = 18'sd2045;
            5:       r = 18'sd1024;
            6:       r = 18'sd512;
            7:       r = 18'sd256;
            8:       r = 18'sd128;
            9:       r = 18'sd64;
            10:      r = 18'sd32;
            11:      r = 18'sd16;
            12:      r = 18'sd8;
            13:      r = 18'sd4;
            14:      r = 18'sd2;
            15:      r = 18'sd1;
            default: r = 18'sd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift index SHIFT.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  cordic_stage_t stage_i,
    output logic          valid_out,
    output cordic_stage_t stage_o
);

    localparam dat_t ATAN = atan_lut(SHIFT);

    cordic_stage_t stage_d, stage_q;
    logic          vld_d, vld_q;
    dat_t          x_in, y_in, z_in, x_sh, y_sh;

    // rotate toward z = 0
    always_comb begin
        stage_d = stage_i;
        vld_d   = valid_in;
        x_in    = stage_i.x;
        y_in    = stage_i.y;
        z_in    = stage_i.z;
        x_sh    = x_in >>> SHIFT;
        y_sh    = y_in >>> SHIFT;
        if (!z_in[INT_W-1]) begin
            stage_d.x = x_in - y_sh;
            stage_d.y = y_in + x_sh;
            stage_d.z = z_in - ATAN;
        end else begin
            stage_d.x = x_in + y_sh;
            stage_d.y = y_in - x_sh;
            stage_d.z = z_in + ATAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
        end
    end

    assign stage_o   = stage_q;
    assign valid_out = vld_q;

endmodule

// File: rtl/cordic_main.sv
// Fully pipelined rotation-mode CORDIC producing Q1.14 cos/sin from a Q2.13 angle.
module cordic_main
    import cordic_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IO_W-1:0] angle,
    input  logic            valid_in,
    output logic [IO_W-1:0] cos_out,
    output logic [IO_W-1:0] sin_out,
    output logic            valid_out
);

    logic signed [IO_W-1:0] ang_d, ang_q;
    logic                   ang_vld_d, ang_vld_q;
    cordic_stage_t          fold_d, fold_q;
    logic                   fold_vld_d, fold_vld_q;
    logic        [IO_W-1:0] cos_d, cos_q, sin_d, sin_q;
    logic                   vout_d, vout_q;
    dat_t                   z_ext;

    cordic_stage_t pipe [ITER+1];
    logic          vld  [ITER+1];

    // negate, round to 2^14 scale and clamp to +/-1.0
    function automatic logic [IO_W-1:0] scale_out(input dat_t v, input logic neg);
        logic signed [INT_W:0] w;
        w = (INT_W+1)'(v);
        if (neg) w = -w;
        w = (w + (INT_W+1)'(2)) >>> 2;
        if (w > (INT_W+1)'(SAT_MAX))       w = (INT_W+1)'(SAT_MAX);
        else if (w < (INT_W+1)'(-SAT_MAX)) w = (INT_W+1)'(-SAT_MAX);
        return IO_W'(w);
    endfunction

    // capture input, then fold into [-pi/2, pi/2] using cos/sin(a -/+ pi) = -cos/sin(a)
    always_comb begin
        ang_d      = $signed(angle);
        ang_vld_d  = valid_in;
        z_ext      = dat_t'(ang_q) <<< Z_SHIFT;
        fold_vld_d = ang_vld_q;
        fold_d     = '{x: dat_t'(K_FIX), y: '0, z: z_ext, neg: 1'b0};
        if (ang_q > HALF_PI_Q13) begin
            fold_d.z   = z_ext - dat_t'(PI_Z);
            fold_d.neg = 1'b1;
        end else if (ang_q < -HALF_PI_Q13) begin
            fold_d.z   = z_ext + dat_t'(PI_Z);
            fold_d.neg = 1'b1;
        end
    end

    assign pipe[0] = fold_q;
    assign vld[0]  = fold_vld_q;

    for (genvar g = 0; g < int'(ITER); g++) begin : g_stage
        cordic_stage #(
            .SHIFT(g)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .valid_in (vld[g]),
            .stage_i  (pipe[g]),
            .valid_out(vld[g+1]),
            .stage_o  (pipe[g+1])
        );
    end

    // outputs update only on valid results and hold otherwise
    always_comb begin
        cos_d  = cos_q;
        sin_d  = sin_q;
        vout_d = vld[ITER];
        if (vld[ITER]) begin
            cos_d = scale_out(pipe[ITER].x, pipe[ITER].neg);
            sin_d = scale_out(pipe[ITER].y, pipe[ITER].neg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ang_q      <= '0;
            ang_vld_q  <= 1'b0;
            fold_q     <= '0;
            fold_vld_q <= 1'b0;
            cos_q      <= '0;
            sin_q      <= '0;
            vout_q     <= 1'b0;
        end else begin
            ang_q      <= ang_d;
            ang_vld_q  <= ang_vld_d;
            fold_q     <= fold_d;
            fold_vld_q <= fold_vld_d;
            cos_q      <= cos_d;
            sin_q      <= sin_d;
            vout_q     <= vout_d;
        end
    end

    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign valid_out = vout_q;

endmodule

// File: tb/tb_cordic_main.sv
// Scoreboard bench for cordic_main: real-math reference, latency, hold and reset checks.
module tb_cordic_main;

    localparam int LAT = 18;
    localparam int TOL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] angle = '0;
    logic        valid_in = 1'b0;
    logic [15:0] cos_out, sin_out;
    logic        valid_out;

    typedef struct {
        logic [15:0] ang;
        int          edge_n;
    } item_t;

    item_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    mon_en  = 1'b0;
    bit    zero_mode = 1'b1;
    int    held_cos = 0;
    int    held_sin = 0;

    cordic_main u_dut (
        .clk      (clk),
        .rst      (rst),
        .angle    (angle),
        .valid_in (valid_in),
        .cos_out  (cos_out),
        .sin_out  (sin_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic int ref_val(input logic [15:0] a, input bit is_sin);
        real r, v;
        int  q;
        r = real'($signed(a)) / 8192.0;
        v = (is_sin ? $sin(r) : $cos(r)) * 16384.0;
        q = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        if (q > 16384)  q = 16384;
        if (q < -16384) q = -16384;
        return q;
    endfunction

    // output monitor, 1 ns after each active edge
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (valid_out === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check_val("spurious_valid", 1, 0, 0);
                    end else begin
                        it = sb_q.pop_front();
                        check_val("latency", cyc - it.edge_n, LAT, 0);
                        check_val($sformatf("cos[%h]", it.ang), int'($signed(cos_out)), ref_val(it.ang, 1'b0), TOL);
                        check_val($sformatf("sin[%h]", it.ang), int'($signed(sin_out)), ref_val(it.ang, 1'b1), TOL);
                        held_cos  = int'($signed(cos_out));
                        held_sin  = int'($signed(sin_out));
                        zero_mode = 1'b0;
                    end
                end else if (valid_out !== 1'b0) begin
                    check_val("valid_x", 1, 0, 0);
                end else if (zero_mode) begin
                    check_val("rst_cos", (cos_out === 16'h0) ? 0 : 1, 0, 0);
                    check_val("rst_sin", (sin_out === 16'h0) ? 0 : 1, 0, 0);
                end else begin
                    check_val("hold_cos", int'($signed(cos_out)), held_cos, 0);
                    check_val("hold_sin", int'($signed(sin_out)), held_sin, 0);
                end
            end
        end
    end

    task automatic send(input logic [15:0] a);
        @(posedge clk);
        #2;
        angle    = a;
        valid_in = 1'b1;
        sb_q.push_back('{ang: a, edge_n: cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            valid_in = 1'b0;
            angle    = 16'($urandom);
        end
    endtask

    // reset with valid_in high: that sample and all in-flight ones are dropped
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        valid_in  = 1'b1;
        angle     = 16'($urandom);
        sb_q.delete();
        zero_mode = 1'b1;
        @(posedge clk);
        #2;
        rst      = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        logic [15:0] edge_vec [6];
        edge_vec = '{16'h6488, 16'h9B78, 16'h7FFF, 16'h8000, 16'h3245, 16'hCDBB};

        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        send(16'h0000);
        idle(24);
        send(16'h10C1);
        idle(24);
        send(16'hCDBC);
        send(16'hCDBC);
        send(16'h3244);
        idle(24);
        foreach (edge_vec[i]) send(edge_vec[i]);
        idle(24);

        for (int i = 0; i < 32; i++) begin
            if (i == 20) pulse_reset();
            send(16'($urandom));
        end

        for (int t = 0; t < 60 && sb_q.size() != 0; t++) idle(1);
        idle(4);
        check_val("sb_empty", sb_q.size(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_main.md
CORDIC_MAIN -- requirements
Module: cordic_main

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port angle, input, 16 bits: signed angle in radians, Q1.2.13 (0x6488 = pi, 0x3244 = pi/2, 0xCDBC = -pi/2).
REQ-004 SHALL have port valid_in, input, 1 bit: angle is valid this cycle; sampled every cycle, no backpressure.
REQ-005 SHALL have port cos_out, output, 16 bits: signed cosine, Q1.1.14 (0x4000 = +1.0, 0xC000 = -1.0).
REQ-006 SHALL have port sin_out, output, 16 bits: signed sine, Q1.1.14.
REQ-007 SHALL have port valid_out, output, 1 bit: cos_out/sin_out valid this cycle.
REQ-008 SHALL have parameter ITER, default 16: number of CORDIC micro-rotation stages.

Function
REQ-009 SHALL be a fully pipelined rotation-mode CORDIC: one new angle accepted per cycle, one result per cycle.
REQ-010 SHALL have fixed latency ITER+2 cycles (18 at default): a valid_in sampled at edge N produces valid_out = 1 with its results after edge N+18.
REQ-011 SHALL propagate valid as a shift register beside the data; valid_out SHALL equal valid_in delayed by exactly the latency; consecutive valid_in cycles give consecutive valid_out cycles in order.
REQ-012 SHALL accept the full 16-bit input range (about -4.0 to +4.0 rad) with no undefined region.
REQ-013 Stage 0 (pre-rotation register) SHALL fold the angle:
- angle > pi/2: z0 = angle - pi, negate flag = 1.
- angle < -pi/2: z0 = angle + pi, negate flag = 1.
- otherwise: z0 = angle, negate flag = 0.
- Exactly +/-pi/2 SHALL not be folded.
REQ-014 Internal x/y width SHALL be 18-bit signed, scaled 2^16; initial x0 = round(K*2^16) = 39797 (K = 0.6072529), y0 = 0.
REQ-015 Internal z SHALL be 18-bit signed, scaled 2^15; input angle is sign-extended and shifted left 2.
REQ-016 Stage i (i = 0..ITER-1) SHALL compute, with d = +1 if z >= 0 else -1, using arithmetic shifts:
- x' = x - d*(y>>>i)
- y' = y + d*(x>>>i)
- z' = z - d*atan_i
- atan_i = round(atan(2^-i)*2^15).
REQ-017 The negate flag SHALL travel through the pipeline with the data.
REQ-018 The output register SHALL:
- apply the negate flag to both x and y;
- round x and y to 2^14 scale (add 2, arithmetic shift right 2);
- saturate to [-16384, +16384];
- drive cos_out from x and sin_out from y.
REQ-019 Accuracy SHALL be within +/-4 LSB of the ideal cos/sin for every input.
REQ-020 While valid_out = 0, cos_out/sin_out SHALL hold their last valid values.

Reset
REQ-021 rst = 1 at a clock edge SHALL clear every pipeline register, the valid pipe, cos_out, sin_out and valid_out to 0.
REQ-022 In-flight samples at reset SHALL be discarded: no valid_out is produced for them.
REQ-023 rst SHALL take priority over valid_in in the same cycle; the first valid_out after rst deasserts SHALL come from an angle sampled after the deassertion.

Structure
REQ-024 Package cordic_pkg SHALL hold:
- widths (16 I/O, 18 internal);
- ITER default;
- K constant;
- PI and PI/2 in Q1.2.13 and z scale;
- the atan_i table.
REQ-025 One sub-module cordic_stage SHALL implement a single registered micro-rotation, parameterized by shift index i; the top SHALL instantiate it ITER times via generate.

Verification
REQ-026 angle 0x0000, 1-cycle valid -> 18 cycles later valid_out = 1 for 1 cycle, cos_out = 0x4000 +/-4, sin_out = 0x0000 +/-4.
REQ-027 angle 0x10C1 (pi/6) -> cos_out = 0x376D +/-4, sin_out = 0x2000 +/-4.
REQ-028 angle 0xCDBC (-pi/2), valid_in high 2 cycles -> two consecutive valid_out cycles, each cos_out ~ 0x0000 +/-4, sin_out = 0xC000 +/-4; then 0x3244 (pi/2) -> sin_out = 0x4000 +/-4.
REQ-029 angle 0x6488 (pi) and 0x9B78 (-pi) -> cos_out = 0xC000 +/-4, sin_out = 0x0000 +/-4 (fold path).
REQ-030 Stream 32 back-to-back random angles, then pulse rst mid-stream -> results match a reference model in order with no gaps; after rst, valid_out = 0 and outputs = 0 until new inputs emerge 18 cycles later.
